// File: rtl/dispense_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispense_pkg
// Purpose  : Shared types and constants for the pill-dispenser scheduler:
//            FSM state encoding, slot index constants, default timing and a
//            helper that packs the three slot pulses into an indexed vector.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package dispense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bit positions of the slot pulses inside the packed slot vector
  localparam int c_slot_m = 0;
  localparam int c_slot_a = 1;
  localparam int c_slot_e = 2;

  // Defaults for a 50 MHz clock: 1 s actuator pulse, 100 ms guard gap
  localparam int c_pulse_cycles_dflt = 50_000_000;
  localparam int c_gap_cycles_dflt   = 5_000_000;
  localparam int c_cnt_w_dflt        = 26;

  function automatic logic [2:0] slot_vec(input logic m, input logic a, input logic e);
    logic [2:0] v;
    v           = '0;
    v[c_slot_m] = m;
    v[c_slot_a] = a;
    v[c_slot_e] = e;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Searches req starting one
//            position after 'last', ascending with wrap; first set bit wins.
// Ports    : req       in  N        request bits
//            last      in  log2(N)  index of the previous grant
//            gnt_idx   out log2(N)  winning index (0 when none)
//            gnt_valid out 1        any request present
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Walk from the lowest priority (k=N, i.e. 'last' itself) to the highest
  // (k=1); later hits overwrite earlier ones so the highest priority wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt_idx   = IDX_W'((int'(last) + k) % N);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dispense_scheduler
// Purpose  : Queues slot/manual dose requests per dispenser and drives one
//            actuator at a time (pulse, then all-off guard gap), granting
//            round-robin so the shared supply never powers two solenoids.
// Ports    : CLOCK_50    in  1       system clock
//            reset       in  1       async active-low reset
//            morningP/afternoonP/eveningP in 1  slot-reached pulses
//            sched_m/a/e in  N_DISP  per-dispenser slot enables
//            manual_req  in  N_DISP  immediate dose request pulses
//            hold        in  1       inhibit new dispenses
//            gpio_out    out N_DISP  actuator drive (one-hot or zero)
//            pending     out N_DISP  queued requests
//            busy        out 1       FIRE or GAP in progress
//            done        out 1       pulse in first GAP cycle
//            overrun     out N_DISP  sticky duplicate-request flags
// Revision : 1.0  initial release
// ============================================================================
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int N_DISP       = 2,
  parameter int PULSE_CYCLES = c_pulse_cycles_dflt,
  parameter int GAP_CYCLES   = c_gap_cycles_dflt,
  parameter int CNT_W        = c_cnt_w_dflt
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              morningP,
  input  logic              afternoonP,
  input  logic              eveningP,
  input  logic [N_DISP-1:0] sched_m,
  input  logic [N_DISP-1:0] sched_a,
  input  logic [N_DISP-1:0] sched_e,
  input  logic [N_DISP-1:0] manual_req,
  input  logic              hold,
  output logic [N_DISP-1:0] gpio_out,
  output logic [N_DISP-1:0] pending,
  output logic              busy,
  output logic              done,
  output logic [N_DISP-1:0] overrun
);

  localparam int IDX_W = $clog2(N_DISP);
  localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_last_rst   = IDX_W'(N_DISP - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic [IDX_W-1:0]   r_last_grant;
  logic [N_DISP-1:0]  r_pending;
  logic [N_DISP-1:0]  r_overrun;
  logic [N_DISP-1:0]  r_gpio;
  logic               r_done;

  logic [2:0]         w_slots;
  logic [N_DISP-1:0]  w_req;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_valid;
  logic               w_grant;
  logic [N_DISP-1:0]  w_gnt_onehot;
  logic [N_DISP-1:0]  w_clear;

  assign w_slots = slot_vec(morningP, afternoonP, eveningP);
  assign w_req   = (w_slots[c_slot_m] ? sched_m : '0)
                 | (w_slots[c_slot_a] ? sched_a : '0)
                 | (w_slots[c_slot_e] ? sched_e : '0)
                 | manual_req;

  rr_arbiter #(.N(N_DISP), .IDX_W(IDX_W)) u_arb (
    .req       (r_pending),
    .last      (r_last_grant),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  assign w_grant      = (r_state == ST_IDLE) && w_gnt_valid && !hold;
  assign w_gnt_onehot = N_DISP'(1) << w_gnt_idx;
  // The granted bit is cleared before new requests are ORed in, so a request
  // for the same dispenser in the grant cycle keeps it queued.
  assign w_clear      = w_grant ? w_gnt_onehot : '0;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_last_grant <= c_last_rst;
      r_pending    <= '0;
      r_overrun    <= '0;
      r_gpio       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_req;
      r_overrun <= r_overrun | (w_req & r_pending);
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state      <= ST_FIRE;
            r_timer      <= '0;
            r_last_grant <= w_gnt_idx;
            r_gpio       <= w_gnt_onehot;
          end
        end
        ST_FIRE: begin
          if (r_timer == c_pulse_last) begin
            r_state <= ST_GAP;
            r_timer <= '0;
            r_gpio  <= '0;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_timer == c_gap_last) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_gpio  <= '0;
        end
      endcase
    end
  end

  assign gpio_out = r_gpio;
  assign pending  = r_pending;
  assign overrun  = r_overrun;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispense_scheduler
// Purpose  : Self-checking bench for dispense_scheduler. A timeline model
//            (grant cycle + fixed pulse/gap windows) predicts every output
//            each cycle; directed scenarios add hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_dispense_scheduler;

  localparam int N = 2;
  localparam int P = 4;
  localparam int G = 2;

  logic         CLOCK_50 = 1'b0;
  logic         reset = 1'b0;
  logic         morningP = 1'b0, afternoonP = 1'b0, eveningP = 1'b0;
  logic [N-1:0] sched_m = '0, sched_a = '0, sched_e = '0, manual_req = '0;
  logic         hold = 1'b0;
  logic [N-1:0] gpio_out, pending, overrun;
  logic         busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dispense_scheduler #(.N_DISP(N), .PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .morningP  (morningP),
    .afternoonP(afternoonP),
    .eveningP  (eveningP),
    .sched_m   (sched_m),
    .sched_a   (sched_a),
    .sched_e   (sched_e),
    .manual_req(manual_req),
    .hold      (hold),
    .gpio_out  (gpio_out),
    .pending   (pending),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A grant decided in cycle g lights the actuator in g+1..g+P, pulses done
  // at g+P+1, keeps busy through g+P+G, and the next decision can happen no
  // earlier than cycle g+P+G+1.
  int           t = 0;
  int           m_g = -1000;
  int           m_idx = 0;
  int           m_last = N - 1;
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_overrun = '0;

  always @(negedge CLOCK_50) begin
    logic [N-1:0] req, e_gpio;
    logic         e_busy, e_done;
    int           pick;
    if (!reset) begin
      m_pending = '0; m_overrun = '0; m_last = N - 1; m_g = -1000;
      check("rst_gpio", 32'(gpio_out), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overrun", 32'(overrun), 0);
    end else begin
      e_gpio = (t >= m_g + 1 && t <= m_g + P) ? N'(1 << m_idx) : '0;
      e_done = (t == m_g + P + 1);
      e_busy = (t >= m_g + 1 && t <= m_g + P + G);
      check("gpio", 32'(gpio_out), 32'(e_gpio));
      check("done", 32'(done), 32'(e_done));
      check("busy", 32'(busy), 32'(e_busy));
      check("pending", 32'(pending), 32'(m_pending));
      check("overrun", 32'(overrun), 32'(m_overrun));
      check("onehot", 32'($countones(gpio_out) <= 1), 1);
      req = (morningP ? sched_m : '0) | (afternoonP ? sched_a : '0)
          | (eveningP ? sched_e : '0) | manual_req;
      m_overrun = m_overrun | (req & m_pending);
      if (!e_busy && m_pending != 0 && !hold) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && m_pending[(m_last + k) % N]) pick = (m_last + k) % N;
        m_g = t; m_idx = pick; m_last = pick;
        m_pending[pick] = 1'b0;
      end
      m_pending = m_pending | req;
    end
    t++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge CLOCK_50);
  endtask

  task automatic clear_inputs();
    morningP = 0; afternoonP = 0; eveningP = 0; manual_req = '0; hold = 0;
  endtask

  task automatic do_reset();
    goto(cyc + 1);
    reset = 0;
    clear_inputs();
    goto(cyc + 3);
    reset = 1;
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b;
    goto(3);
    reset = 1;

    // 1: single morning dose for dispenser 0
    b = cyc; sched_m = 2'b01;
    goto(b + 10); morningP = 1;
    goto(b + 11); morningP = 0;
    at_neg(b + 12); check("t1_gpio_first", 32'(gpio_out), 1);
    at_neg(b + 15); check("t1_gpio_last", 32'(gpio_out), 1);
    at_neg(b + 16); check("t1_gpio_off", 32'(gpio_out), 0);
    check("t1_done", 32'(done), 1);
    at_neg(b + 18); check("t1_busy_low", 32'(busy), 0);
    check("t1_pending", 32'(pending), 0);

    // 2: both dispensers on the morning slot
    do_reset(); b = cyc; sched_m = 2'b11;
    goto(b + 10); morningP = 1;
    goto(b + 11); morningP = 0;
    at_neg(b + 12); check("t2_d0", 32'(gpio_out), 1);
    at_neg(b + 17); check("t2_gap", 32'(gpio_out), 0);
    at_neg(b + 18); check("t2_idle_busy", 32'(busy), 0);
    at_neg(b + 19); check("t2_d1", 32'(gpio_out), 2);
    at_neg(b + 22); check("t2_d1_last", 32'(gpio_out), 2);

    // 3: duplicate manual requests
    do_reset(); b = cyc;
    goto(b + 10); manual_req = 2'b01;
    goto(b + 11); manual_req = 2'b01;
    goto(b + 12); manual_req = 2'b00;
    #3; check("t3_overrun", 32'(overrun), 1);
    goto(b + 13); manual_req = 2'b01;
    goto(b + 14); manual_req = 2'b00;
    at_neg(b + 19); check("t3_second_pulse", 32'(gpio_out), 1);
    at_neg(b + 23); check("t3_after", 32'(gpio_out), 0);
    check("t3_overrun_kept", 32'(overrun), 1);

    // 4: hold parks a queued evening dose
    do_reset(); b = cyc; sched_e = 2'b10;
    goto(b + 5); hold = 1;
    goto(b + 10); eveningP = 1;
    goto(b + 11); eveningP = 0;
    at_neg(b + 20); check("t4_pending", 32'(pending), 2);
    check("t4_gpio_held", 32'(gpio_out), 0);
    goto(b + 30); hold = 0;
    at_neg(b + 31); check("t4_first", 32'(gpio_out), 2);
    at_neg(b + 34); check("t4_last", 32'(gpio_out), 2);
    at_neg(b + 35); check("t4_off", 32'(gpio_out), 0);

    // 5: asynchronous reset in mid-pulse
    do_reset(); b = cyc;
    goto(b + 10); manual_req = 2'b01;
    goto(b + 11); manual_req = 2'b10;
    goto(b + 12); manual_req = 2'b00;
    goto(b + 13); #2; reset = 0; #1;
    check("t5_async_gpio", 32'(gpio_out), 0);
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_pending", 32'(pending), 0);
    goto(b + 15); reset = 1;
    goto(b + 20); manual_req = 2'b11;
    goto(b + 21); manual_req = 2'b00;
    at_neg(b + 22); check("t5_disp0_first", 32'(gpio_out), 1);
    at_neg(b + 29); check("t5_disp1_next", 32'(gpio_out), 2);

    // 6: round-robin under continuous requests
    do_reset(); b = cyc;
    goto(b + 10); manual_req = 2'b11;
    at_neg(b + 12); check("t6_g0", 32'(gpio_out), 1);
    at_neg(b + 19); check("t6_g1", 32'(gpio_out), 2);
    at_neg(b + 20); check("t6_overrun", 32'(overrun), 3);
    at_neg(b + 26); check("t6_g2", 32'(gpio_out), 1);
    at_neg(b + 33); check("t6_g3", 32'(gpio_out), 2);
    goto(b + 50); manual_req = 2'b00;

    // Random traffic against the model
    do_reset();
    sched_m = N'($urandom); sched_a = N'($urandom); sched_e = N'($urandom);
    for (int i = 0; i < 600; i++) begin
      goto(cyc + 1);
      morningP   = ($urandom_range(0, 15) == 0);
      afternoonP = ($urandom_range(0, 15) == 0);
      eveningP   = ($urandom_range(0, 15) == 0);
      for (int d = 0; d < N; d++) manual_req[d] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 99) == 0) begin
        sched_m = N'($urandom); sched_a = N'($urandom); sched_e = N'($urandom);
      end
    end
    clear_inputs();
    goto(cyc + 20);
    @(negedge CLOCK_50);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
